// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared state, command and position encodings for the servo command sequencer
package servo_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_e;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_GRIP    = 2'b01;
  localparam logic [1:0] CMD_RELEASE = 2'b10;

  localparam logic POS_RELEASE = 1'b0;
  localparam logic POS_GRIP    = 1'b1;

  function automatic logic [1:0] pos_to_cmd(input logic pos);
    return (pos == POS_GRIP) ? CMD_GRIP : CMD_RELEASE;
  endfunction

endpackage

// File: rtl/servo_settle_timer.sv
// rtl/servo_settle_timer.sv - mechanical settle counter with clear/enable and terminal count
module servo_settle_timer #(
  parameter int SETTLE_CYCLES = 25_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  // Holding at terminal count keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && !tc_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// rtl/servo_cmd_sequencer.sv - grip/release request sequencer for the servo PWM generator; SERVO_QUEUE_EN adds a one-entry pending buffer
module servo_cmd_sequencer
  import servo_pkg::*;
#(
  parameter int SETTLE_CYCLES = 25_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_pos,
  output logic       req_ready,
  output logic [1:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       arm_pos
);

  state_e     state_q;
  logic [1:0] cmd_q;
  logic       busy_q, done_q, arm_pos_q, target_q;
  logic       accept, settle_tc;
  logic       launch_v, launch_pos, ref_pos;

`ifdef SERVO_QUEUE_EN
  logic pend_q, pend_pos_q;
  assign req_ready = (state_q == IDLE) || !pend_q;
`else
  assign req_ready = (state_q == IDLE);
`endif

  assign accept  = req_valid && req_ready;
  assign cmd     = cmd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign arm_pos = arm_pos_q;

  // A new move starts from IDLE, or from DONE when a request is waiting;
  // in DONE it is compared against the position being committed this cycle.
  always_comb begin
    launch_v   = 1'b0;
    launch_pos = req_pos;
    ref_pos    = arm_pos_q;
    if (state_q == IDLE)
      launch_v = accept;
`ifdef SERVO_QUEUE_EN
    else if (state_q == DONE) begin
      ref_pos = target_q;
      if (pend_q) begin
        launch_v   = 1'b1;
        launch_pos = pend_pos_q;
      end else begin
        launch_v = accept;
      end
    end
`endif
  end

  servo_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == ISSUE),
    .enable_i(state_q == SETTLE),
    .tc_o    (settle_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_NOP;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arm_pos_q  <= POS_RELEASE;
      target_q   <= POS_RELEASE;
`ifdef SERVO_QUEUE_EN
      pend_q     <= 1'b0;
      pend_pos_q <= POS_RELEASE;
`endif
    end else begin
      cmd_q  <= CMD_NOP;
      done_q <= 1'b0;
      case (state_q)
        IDLE:    ;
        ISSUE:   state_q <= SETTLE;
        SETTLE: begin
          if (settle_tc) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          arm_pos_q <= target_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (launch_v) begin
        target_q <= launch_pos;
        if (launch_pos == ref_pos) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= ISSUE;
          cmd_q   <= pos_to_cmd(launch_pos);
          busy_q  <= 1'b1;
        end
      end

`ifdef SERVO_QUEUE_EN
      if (accept && (state_q == ISSUE || state_q == SETTLE)) begin
        pend_q     <= 1'b1;
        pend_pos_q <= req_pos;
      end else if (state_q == DONE) begin
        pend_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// tb/tb_servo_cmd_sequencer.sv - scoreboard bench for servo_cmd_sequencer (SERVO_QUEUE_EN selects the queue scenario)
module tb_servo_cmd_sequencer;

  localparam int SC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_pos = 1'b0;
  logic       req_ready;
  logic [1:0] cmd;
  logic       busy, done, arm_pos;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [1:0] cmd;
    logic       done;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  servo_cmd_sequencer #(.SETTLE_CYCLES(SC), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_pos  (req_pos),
    .req_ready(req_ready),
    .cmd      (cmd),
    .busy     (busy),
    .done     (done),
    .arm_pos  (arm_pos)
  );

  function automatic ev_t mk(input int c, input logic [1:0] m, input logic d);
    ev_t e;
    e.cyc = c; e.cmd = m; e.done = d;
    return e;
  endfunction

  // Present a request from the current falling edge until it is taken; t is the accept cycle.
  task automatic accept(input logic pos, output int t);
    int w = 0;
    req_valid = 1'b1;
    req_pos   = pos;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd !== 2'b00) begin n_bad++; $display("FAIL reset_cmd: got %b required 00", cmd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (arm_pos !== 1'b0) begin n_bad++; $display("FAIL reset_arm_pos: got %b required 0", arm_pos); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_grip();
    int t;
    ev_t e;
    logic busy_ok = 1'b1;
    accept(1'b1, t);
    exp_q.push_back(mk(t + 1, 2'b01, 1'b0));
    exp_q.push_back(mk(t + 2 + SC, 2'b00, 1'b1));
    for (int i = 0; i < 20; i++) begin
      if (cmd !== 2'b00 || done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL grip_event: got cmd=%b done=%b at %0d required no event", cmd, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cmd !== cmd || e.done !== done) begin
            n_bad++; $display("FAIL grip_event: got cyc=%0d cmd=%b done=%b required cyc=%0d cmd=%b done=%b", cyc, cmd, done, e.cyc, e.cmd, e.done);
          end
        end
      end
      if (busy !== ((cyc >= t + 1) && (cyc <= t + 1 + SC))) busy_ok = 1'b0;
      if (cyc == t + 2 + SC) begin
        n_cmp++; if (arm_pos !== 1'b0) begin n_bad++; $display("FAIL grip_arm_in_done: got %b required 0", arm_pos); end
      end
      if (cyc == t + 3 + SC) begin
        n_cmp++; if (arm_pos !== 1'b1) begin n_bad++; $display("FAIL grip_arm_after: got %b required 1", arm_pos); end
      end
      @(negedge clk);
    end
    n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL grip_busy_window: got mismatched busy required 1 over t+1..t+%0d", 1 + SC); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL grip_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_no_move();
    int t;
    ev_t e;
    accept(1'b1, t);
    exp_q.push_back(mk(t + 1, 2'b00, 1'b1));
    for (int i = 0; i < 6; i++) begin
      if (cmd !== 2'b00 || done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL nomove_event: got cmd=%b done=%b at %0d required no event", cmd, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cmd !== cmd || e.done !== done) begin
            n_bad++; $display("FAIL nomove_event: got cyc=%0d cmd=%b done=%b required cyc=%0d cmd=%b done=%b", cyc, cmd, done, e.cyc, e.cmd, e.done);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++; if (arm_pos !== 1'b1) begin n_bad++; $display("FAIL nomove_arm: got %b required 1", arm_pos); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL nomove_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int t;
    ev_t e;
    accept(1'b0, t);
    exp_q.push_back(mk(t + 1, 2'b10, 1'b0));
    for (int i = 0; i < 25; i++) begin
      if (cmd !== 2'b00 || done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rstmid_event: got cmd=%b done=%b at %0d required no event", cmd, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cmd !== cmd || e.done !== done) begin
            n_bad++; $display("FAIL rstmid_event: got cyc=%0d cmd=%b done=%b required cyc=%0d cmd=%b done=%b", cyc, cmd, done, e.cyc, e.cmd, e.done);
          end
        end
      end
      if (cyc == t + 8) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        n_cmp++; if (arm_pos !== 1'b0) begin n_bad++; $display("FAIL rstmid_arm: got %b required 0", arm_pos); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b required 1", req_ready); end
      end
      if (cyc == t + 7) rst_n = 1'b0;
      if (cyc == t + 9) rst_n = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rstmid_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_busy_reject();
    int t;
    ev_t e;
    accept(1'b1, t);
    exp_q.push_back(mk(t + 1, 2'b01, 1'b0));
    exp_q.push_back(mk(t + 2 + SC, 2'b00, 1'b1));
    for (int i = 0; i < 22; i++) begin
      if (cmd !== 2'b00 || done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL reject_event: got cmd=%b done=%b at %0d required no event", cmd, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cmd !== cmd || e.done !== done) begin
            n_bad++; $display("FAIL reject_event: got cyc=%0d cmd=%b done=%b required cyc=%0d cmd=%b done=%b", cyc, cmd, done, e.cyc, e.cmd, e.done);
          end
        end
      end
      if (cyc >= t + 3 && cyc <= t + 8) begin
        req_valid = 1'b1;
        req_pos   = 1'b0;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reject_ready: got %b at %0d required 0", req_ready, cyc); end
      end else begin
        req_valid = 1'b0;
      end
      if (cyc == t + 3 + SC) begin
        n_cmp++; if (arm_pos !== 1'b1) begin n_bad++; $display("FAIL reject_arm: got %b required 1", arm_pos); end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL reject_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_queue();
    int t;
    ev_t e;
    accept(1'b1, t);
    exp_q.push_back(mk(t + 1, 2'b01, 1'b0));
    exp_q.push_back(mk(t + 2 + SC, 2'b00, 1'b1));
    exp_q.push_back(mk(t + 3 + SC, 2'b10, 1'b0));
    exp_q.push_back(mk(t + 4 + 2 * SC, 2'b00, 1'b1));
    for (int i = 0; i < 35; i++) begin
      if (cmd !== 2'b00 || done !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL queue_event: got cmd=%b done=%b at %0d required no event", cmd, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cmd !== cmd || e.done !== done) begin
            n_bad++; $display("FAIL queue_event: got cyc=%0d cmd=%b done=%b required cyc=%0d cmd=%b done=%b", cyc, cmd, done, e.cyc, e.cmd, e.done);
          end
        end
      end
      if (cyc == t + 4) begin
        req_valid = 1'b1;
        req_pos   = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL queue_ready: got %b required 1", req_ready); end
      end else begin
        req_valid = 1'b0;
      end
      if (cyc == t + 5 + 2 * SC) begin
        n_cmp++; if (arm_pos !== 1'b0) begin n_bad++; $display("FAIL queue_arm: got %b required 0", arm_pos); end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL queue_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_grip();
    test_no_move();
    test_reset_mid();
`ifdef SERVO_QUEUE_EN
    test_queue();
`else
    test_busy_reject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/servo_cmd_sequencer.md
Name: servo_cmd_sequencer

Overview:
- Upstream stage of the gripper servo PWM generator. Drives that block's 2-bit cmd input.
- Accepts one grip or release request per valid/ready handshake from the task controller.
- Issues a one-cycle cmd pulse, waits a fixed mechanical settle time, then reports completion and the resulting arm position.
- Requests that match the current position complete without moving the servo.

Parameters:
- SETTLE_CYCLES, 25_000_000: clock cycles to wait after a cmd pulse (500 ms at 50 MHz).
- CNT_W, 25: settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_pos  input  1  requested position: 1 = grip (1 ms pulse), 0 = release (2 ms pulse)
- req_ready  output  1  block can accept a request this cycle
- cmd  output  2  to servo PWM generator: 01 = grip, 10 = release, 00 = no-op; 11 never driven
- busy  output  1  move in progress
- done  output  1  one-cycle completion pulse
- arm_pos  output  1  last commanded position, updated when done pulses

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low and is sampled only on the clk rising edge.
- Reset values: state = IDLE, cmd = 00, busy = 0, done = 0, req_ready = 1, arm_pos = 0, counter = 0.
  - arm_pos = 0 matches the servo's power-on 2 ms (release) pulse.
- Handshake: a request is accepted on the cycle where req_valid && req_ready. req_pos is captured into an internal target register at that cycle.
- States:
  - IDLE: req_ready = 1.
    - Accept with target == arm_pos → DONE. This is a no-move: cmd stays 00 and done pulses on the next cycle.
    - Accept with target != arm_pos → ISSUE.
  - ISSUE: one cycle. cmd = 01 if target = 1, else 10. busy = 1, counter is cleared. Next state SETTLE.
  - SETTLE: cmd = 00, busy = 1, counter increments each cycle. When counter == SETTLE_CYCLES-1 → DONE.
  - DONE: one cycle. done = 1, arm_pos <= target, busy = 0. Next state IDLE.
- req_ready is 0 in ISSUE, SETTLE and DONE. Back-to-back moves are therefore separated by at least SETTLE_CYCLES+2 cycles, well above the servo's minimum 2-cycle re-arm gap.
- Latency for a real move: accept at cycle t; cmd pulse at t+1; done at t+2+SETTLE_CYCLES.
- Latency for a no-move: done at t+1.
- cmd is registered and is never nonzero for more than one consecutive cycle.
- Reset mid-operation: on the next edge the block returns to reset values. cmd is forced to 00 and arm_pos returns to 0 regardless of physical position. The servo's own reset restores the release pulse, so the two stay consistent.
- req_valid asserted while not ready is ignored: no capture and no side effect.
- The counter does not wrap: it is cleared in ISSUE and saturates by leaving SETTLE.

Optional Feature:
- Macro: SERVO_QUEUE_EN.
- Enabled:
  - A one-entry pending buffer (valid bit + position) is added.
  - req_ready = 1 in every state whenever the buffer is empty, and in IDLE.
  - A request accepted while busy is stored in the buffer.
  - In DONE, if the buffer is valid, the next state evaluates the buffered request exactly as IDLE would: ISSUE or no-move DONE, against the updated arm_pos. The buffer is cleared.
  - A request arriving in the same cycle the buffer drains is accepted into the now-empty buffer only from the following cycle.
- Disabled: behaviour exactly as above, with no buffer logic.

Decomposition:
- Shared package servo_pkg holds:
  - state enum IDLE/ISSUE/SETTLE/DONE;
  - constants CMD_NOP = 2'b00, CMD_GRIP = 2'b01, CMD_RELEASE = 2'b10;
  - POS_RELEASE = 0, POS_GRIP = 1.
- One natural sub-module: servo_settle_timer, which provides clear/enable inputs and a terminal-count output, parameterized by SETTLE_CYCLES and CNT_W. Everything else stays in the top module.

Test Plan (SETTLE_CYCLES = 10):
- Reset: hold rst_n = 0 for 3 cycles → cmd = 00, busy = 0, done = 0, arm_pos = 0, req_ready = 1.
- Grip from reset: req_pos = 1 accepted at t → cmd = 01 at t+1 only, busy = 1 over t+1..t+11, done at t+12, arm_pos = 1 from t+13.
- No-move: with arm_pos = 1, request req_pos = 1 → done at t+1, cmd stays 00 throughout, arm_pos unchanged.
- Busy reject: drive req_valid = 1 with req_pos = 0 during SETTLE → req_ready = 0, no extra cmd pulse, arm_pos still reflects the original move after done.
- Reset mid-SETTLE: assert rst_n = 0 at counter = 5 → next edge has cmd = 00, busy = 0, arm_pos = 0, no done pulse.
- SERVO_QUEUE_EN: grip accepted, then release accepted during SETTLE → cmd 01, done, then cmd 10 on the cycle after DONE, second done 12 cycles later, final arm_pos = 0.
